// File: rtl/uart_board_frame_decoder.sv
// Receive-side parser for the Life board UART stream: locks onto ESC [ ; H,
// then turns the 'O'/' ' grid into per-cell write strobes plus frame/error statistics.
module uart_board_frame_decoder #(
    parameter int unsigned logWIDTH  = 4,
    parameter int unsigned logHEIGHT = 4
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [7:0]                     in_data,
    input  logic                           in_valid,
    output logic                           in_ready,
    output logic                           cell_we,
    output logic [logWIDTH+logHEIGHT-1:0]  cell_addr,
    output logic                           cell_data,
    output logic                           frame_done,
    output logic [7:0]                     frame_count,
    output logic [logWIDTH+logHEIGHT:0]    frame_pop,
    output logic                           err,
    output logic [7:0]                     err_count,
    output logic                           busy
);

    localparam int unsigned AW = logWIDTH + logHEIGHT;
    localparam int unsigned PW = AW + 1;

    localparam logic [7:0] CH_ESC  = 8'h1B;
    localparam logic [7:0] CH_BRK  = 8'h5B;
    localparam logic [7:0] CH_SEMI = 8'h3B;
    localparam logic [7:0] CH_H    = 8'h48;
    localparam logic [7:0] CH_O    = 8'h4F;
    localparam logic [7:0] CH_SP   = 8'h20;
    localparam logic [7:0] CH_CR   = 8'h0D;
    localparam logic [7:0] CH_LF   = 8'h0A;

    typedef enum logic [2:0] {
        S_HUNT, S_GOT_ESC, S_GOT_BRK, S_GOT_SEMI, S_CELLS, S_EXP_CR, S_EXP_LF
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_in_ready;
    logic                  r_cell_we;
    logic [AW-1:0]         r_cell_addr;
    logic                  r_cell_data;
    logic                  r_frame_done;
    logic [7:0]            r_frame_count;
    logic [PW-1:0]         r_frame_pop;
    logic                  r_err;
    logic [7:0]            r_err_count;
    logic                  r_busy;
    logic [logWIDTH-1:0]   r_col;
    logic [logHEIGHT-1:0]  r_row;
    logic [PW-1:0]         r_pop;

    logic w_acc, w_is_live, w_is_cell;
    logic w_wr, w_last, w_home, w_row_inc, w_bad;

    assign w_acc     = in_valid && r_in_ready;
    assign w_is_live = (in_data == CH_O);
    assign w_is_cell = w_is_live || (in_data == CH_SP);

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_HUNT;
        else       r_state <= w_state_nxt;
    end

    // Next-state decode and per-byte control strobes
    always_comb begin
        w_state_nxt = r_state;
        w_wr        = 1'b0;
        w_last      = 1'b0;
        w_home      = 1'b0;
        w_row_inc   = 1'b0;
        w_bad       = 1'b0;
        if (w_acc) begin
            case (r_state)
                S_HUNT:     if (in_data == CH_ESC) w_state_nxt = S_GOT_ESC;
                S_GOT_ESC:  if (in_data == CH_BRK) w_state_nxt = S_GOT_BRK; else w_bad = 1'b1;
                S_GOT_SEMI: if (in_data == CH_H) begin
                                w_home      = 1'b1;
                                w_state_nxt = S_CELLS;
                            end else w_bad = 1'b1;
                S_GOT_BRK:  if (in_data == CH_SEMI) w_state_nxt = S_GOT_SEMI; else w_bad = 1'b1;
                S_CELLS: begin
                    if (w_is_cell) begin
                        w_wr = 1'b1;
                        if (&r_col) begin
                            if (&r_row) begin
                                w_last      = 1'b1;
                                w_state_nxt = S_HUNT;
                            end else begin
                                w_state_nxt = S_EXP_CR;
                            end
                        end
                    end else begin
                        w_bad = 1'b1;
                    end
                end
                S_EXP_CR:   if (in_data == CH_CR) w_state_nxt = S_EXP_LF; else w_bad = 1'b1;
                S_EXP_LF:   if (in_data == CH_LF) begin
                                w_row_inc   = 1'b1;
                                w_state_nxt = S_CELLS;
                            end else w_bad = 1'b1;
                default:    w_state_nxt = S_HUNT;
            endcase
            // An ESC anywhere mid-frame restarts the home sequence
            if (w_bad) w_state_nxt = (in_data == CH_ESC) ? S_GOT_ESC : S_HUNT;
        end
    end

    // Datapath, strobes and statistics
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_in_ready    <= 1'b0;
            r_cell_we     <= 1'b0;
            r_cell_addr   <= '0;
            r_cell_data   <= 1'b0;
            r_frame_done  <= 1'b0;
            r_frame_count <= '0;
            r_frame_pop   <= '0;
            r_err         <= 1'b0;
            r_err_count   <= '0;
            r_busy        <= 1'b0;
            r_col         <= '0;
            r_row         <= '0;
            r_pop         <= '0;
        end else begin
            r_in_ready   <= 1'b1;
            r_cell_we    <= w_wr;
            r_frame_done <= w_last;
            r_err        <= w_bad;
            r_busy       <= (w_state_nxt != S_HUNT);
            if (w_home) begin
                r_col <= '0;
                r_row <= '0;
                r_pop <= '0;
            end
            if (w_wr) begin
                r_cell_addr <= {r_row, r_col};
                r_cell_data <= w_is_live;
                r_col       <= r_col + logWIDTH'(1);
                r_pop       <= r_pop + PW'(w_is_live);
            end
            if (w_row_inc) begin
                r_row <= r_row + logHEIGHT'(1);
                r_col <= '0;
            end
            if (w_last) begin
                r_frame_pop   <= r_pop + PW'(w_is_live);
                r_frame_count <= r_frame_count + 8'd1;
            end
            if (w_bad && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'd1;
        end
    end

    assign in_ready    = r_in_ready;
    assign cell_we     = r_cell_we;
    assign cell_addr   = r_cell_addr;
    assign cell_data   = r_cell_data;
    assign frame_done  = r_frame_done;
    assign frame_count = r_frame_count;
    assign frame_pop   = r_frame_pop;
    assign err         = r_err;
    assign err_count   = r_err_count;
    assign busy        = r_busy;

endmodule
